// File: rtl/subleq_pkg.sv
// subleq_pkg: shared state type, instruction field helpers and the
// configuration check used by subleq_core.
package subleq_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    FETCH  = 3'd1,
    LOAD_A = 3'd2,
    LOAD_B = 3'd3,
    WRITE  = 3'd4,
    HALT   = 3'd5
  } state_t;

  // Widest instruction word the field helpers accept.
  localparam int unsigned FLD_MAX_W = 256;

  typedef logic [FLD_MAX_W-1:0] fld_word_t;

  function automatic fld_word_t fld_mask(
    input int unsigned aw
  );
    fld_word_t m;
    m = '1;
    return m >> (FLD_MAX_W - aw);
  endfunction

  function automatic fld_word_t fld_a(
    input fld_word_t   w,
    input int unsigned aw
  );
    return (w >> (2 * aw)) & fld_mask(aw);
  endfunction

  function automatic fld_word_t fld_b(
    input fld_word_t   w,
    input int unsigned aw
  );
    return (w >> aw) & fld_mask(aw);
  endfunction

  function automatic fld_word_t fld_j(
    input fld_word_t   w,
    input int unsigned aw
  );
    return w & fld_mask(aw);
  endfunction

  // The word must hold three address fields.
  function automatic bit cfg_ok(
    input int unsigned dw,
    input int unsigned aw
  );
    return (aw > 0) && (dw >= 3 * aw) && (dw <= FLD_MAX_W);
  endfunction

endpackage

// File: rtl/subleq_alu.sv
// subleq_alu: res = vb - va (wrapping) and the signed res <= 0 test.
// Ports: va, vb in; res, leq out. Purely combinational.
module subleq_alu #(
  parameter int unsigned DATA_W = 64
) (
  input  logic [DATA_W-1:0] va,
  input  logic [DATA_W-1:0] vb,
  output logic [DATA_W-1:0] res,
  output logic              leq
);

  assign res = vb - va;
  // Negative (sign bit) or exactly zero.
  assign leq = res[DATA_W-1] | (res == '0);

endmodule

// File: rtl/subleq_core.sv
// subleq_core: multi-cycle SUBLEQ CPU, one memory access per state.
// Ports: iCLK/iRST_N clock and async reset, iRUN start level,
//   oMEM_* / iMEM_* single-port req/ack memory, oIP/oBUSY/oHALT status.
// `define SUBLEQ_TRACE_EN adds oTRC_VALID/IP/RES/TAKEN retire trace.
module subleq_core
  import subleq_pkg::*;
#(
  parameter int unsigned       DATA_W   = 64,
  parameter int unsigned       ADDR_W   = 13,
  parameter bit                REL_ADDR = 1'b1,
  parameter logic [ADDR_W-1:0] RESET_IP = '0
) (
  input  logic              iCLK,
  input  logic              iRST_N,
  input  logic              iRUN,
  output logic              oMEM_REQ,
  output logic              oMEM_WE,
  output logic [ADDR_W-1:0] oMEM_ADDR,
  output logic [DATA_W-1:0] oMEM_WDATA,
  input  logic              iMEM_ACK,
  input  logic [DATA_W-1:0] iMEM_RDATA,
  output logic [ADDR_W-1:0] oIP,
  output logic              oBUSY,
  output logic              oHALT
`ifdef SUBLEQ_TRACE_EN
  ,
  output logic              oTRC_VALID,
  output logic [ADDR_W-1:0] oTRC_IP,
  output logic [DATA_W-1:0] oTRC_RES,
  output logic              oTRC_TAKEN
`endif
);

  if (!cfg_ok(DATA_W, ADDR_W)) begin : g_cfg_bad
    $error("subleq_core: need DATA_W >= 3*ADDR_W");
  end

  state_t            state;
  logic [ADDR_W-1:0] ip;
  logic [ADDR_W-1:0] a_q;
  logic [ADDR_W-1:0] b_q;
  logic [ADDR_W-1:0] j_q;
  logic [DATA_W-1:0] va;
  logic [DATA_W-1:0] vb;
  logic [DATA_W-1:0] res;
  logic              leq;

  logic [ADDR_W-1:0] ea;
  logic [ADDR_W-1:0] eb;
  logic [ADDR_W-1:0] ej;
  logic [ADDR_W-1:0] ip_nxt;
  logic              done;
  logic              wr_done;
  logic              self_loop;

  function automatic logic [ADDR_W-1:0] eff(
    input logic [ADDR_W-1:0] base,
    input logic [ADDR_W-1:0] x
  );
    return REL_ADDR ? base + x : x;
  endfunction

  subleq_alu #(
    .DATA_W(DATA_W)
  ) u_alu (
    .va  (va),
    .vb  (vb),
    .res (res),
    .leq (leq)
  );

  assign ea = eff(ip, a_q);
  assign eb = eff(ip, b_q);
  assign ej = eff(ip, j_q);

  assign done      = oMEM_REQ & iMEM_ACK;
  assign wr_done   = done & (state == WRITE);
  assign self_loop = leq & (ej == ip);
  assign ip_nxt    = leq ? ej : ip + 1'b1;

  // Bus outputs decode straight from registered state, so they stay
  // put across wait cycles and vanish the moment reset hits.
  always_comb begin
    oMEM_REQ   = 1'b0;
    oMEM_WE    = 1'b0;
    oMEM_ADDR  = '0;
    oMEM_WDATA = '0;
    unique case (1'b1)
      (state == FETCH): begin
        oMEM_REQ  = 1'b1;
        oMEM_ADDR = ip;
      end
      (state == LOAD_A): begin
        oMEM_REQ  = 1'b1;
        oMEM_ADDR = ea;
      end
      (state == LOAD_B): begin
        oMEM_REQ  = 1'b1;
        oMEM_ADDR = eb;
      end
      (state == WRITE): begin
        oMEM_REQ   = 1'b1;
        oMEM_WE    = 1'b1;
        oMEM_ADDR  = eb;
        oMEM_WDATA = res;
      end
      default: ;
    endcase
  end

  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) begin
      state <= IDLE;
      ip    <= RESET_IP;
      a_q   <= '0;
      b_q   <= '0;
      j_q   <= '0;
      va    <= '0;
      vb    <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (iRUN) state <= FETCH;
        end
        FETCH: begin
          if (done) begin
            a_q <= ADDR_W'(fld_a(fld_word_t'(iMEM_RDATA), ADDR_W));
            b_q <= ADDR_W'(fld_b(fld_word_t'(iMEM_RDATA), ADDR_W));
            j_q <= ADDR_W'(fld_j(fld_word_t'(iMEM_RDATA), ADDR_W));
            state <= LOAD_A;
          end
        end
        LOAD_A: begin
          if (done) begin
            va    <= iMEM_RDATA;
            state <= LOAD_B;
          end
        end
        LOAD_B: begin
          if (done) begin
            vb    <= iMEM_RDATA;
            state <= WRITE;
          end
        end
        WRITE: begin
          if (wr_done) begin
            if (self_loop) begin
              state <= HALT;
            end else begin
              ip    <= ip_nxt;
              state <= iRUN ? FETCH : IDLE;
            end
          end
        end
        HALT: ;
        default: state <= IDLE;
      endcase
    end
  end

  assign oIP   = ip;
  assign oHALT = (state == HALT);
  assign oBUSY = (state != IDLE) && (state != HALT);

`ifdef SUBLEQ_TRACE_EN
  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) begin
      oTRC_VALID <= 1'b0;
      oTRC_IP    <= '0;
      oTRC_RES   <= '0;
      oTRC_TAKEN <= 1'b0;
    end else begin
      oTRC_VALID <= wr_done;
      if (wr_done) begin
        oTRC_IP    <= ip;
        oTRC_RES   <= res;
        oTRC_TAKEN <= leq;
      end
    end
  end
`endif

endmodule

// File: doc/subleq_core.md
Name: subleq_core

Overview:
- Parametrised multi-cycle SUBLEQ processor core: mem[B] <= mem[B] - mem[A]; branch to J if the result is <= 0 (signed).
- Generalises data width and address width, and selects relative or absolute operand addressing.
- Memory is external, behind a single-port req/ack interface, so it can be backed by on-chip RAM or a bus bridge.
- Adds run control, halt detection and a correct signed branch test.

Parameters:
- DATA_W, 64, memory word width. Must satisfy DATA_W >= 3*ADDR_W.
- ADDR_W, 13, word-address width. All address arithmetic is modulo 2^ADDR_W.
- REL_ADDR, 1, 1: A, B and J are offsets added to IP. 0: A, B and J are absolute addresses.
- RESET_IP, 0, IP value loaded on reset.

Ports:
- iCLK, in, 1, clock; all state changes on its rising edge.
- iRST_N, in, 1, asynchronous active-low reset.
- iRUN, in, 1, level. Core may start a new instruction only while high.
- oMEM_REQ, out, 1, memory transaction request.
- oMEM_WE, out, 1, 1 = write, 0 = read. Valid while oMEM_REQ is high.
- oMEM_ADDR, out, ADDR_W, transaction address.
- oMEM_WDATA, out, DATA_W, write data.
- iMEM_ACK, in, 1, transaction completes on an edge where oMEM_REQ && iMEM_ACK.
- iMEM_RDATA, in, DATA_W, read data. Sampled on the completing edge.
- oIP, out, ADDR_W, current instruction pointer.
- oBUSY, out, 1, high in any state other than IDLE and HALT.
- oHALT, out, 1, core has halted.

Behaviour:
- Instruction word fields:
  - A = word[3*ADDR_W-1:2*ADDR_W]
  - B = word[2*ADDR_W-1:ADDR_W]
  - J = word[ADDR_W-1:0]
  - Bits above 3*ADDR_W are ignored.
- Effective address: eff(x) = REL_ADDR ? IP + x : x, truncated to ADDR_W.
- States and transitions:
  - IDLE -> FETCH when iRUN = 1.
  - FETCH: read IP; latch A, B, J. -> LOAD_A.
  - LOAD_A: read eff(A); latch va. -> LOAD_B.
  - LOAD_B: read eff(B); latch vb. -> WRITE.
  - WRITE: write res = vb - va (mod 2^DATA_W) to eff(B).
- Each memory state holds oMEM_REQ, oMEM_WE, oMEM_ADDR and oMEM_WDATA stable until the completing edge. It advances on that edge.
- Zero-wait memory (ACK tied high) gives exactly 4 cycles per instruction. Each wait cycle adds 1 cycle.
- Between transactions:
  - oMEM_REQ stays high when the next state is also a memory state; back-to-back transactions are allowed.
  - iMEM_ACK while oMEM_REQ = 0 is ignored.
- Branch: leq = ($signed(res) <= 0). On WRITE completion:
  - nextIP = leq ? eff(J) : IP + 1 (wraps at 2^ADDR_W).
  - If leq and eff(J) == IP, the instruction is a self-loop: go to HALT. IP stays unchanged, oHALT = 1, oMEM_REQ = 0.
  - Otherwise IP <= nextIP, then FETCH if iRUN = 1, else IDLE.
- iRUN is only examined at instruction boundaries. Deasserting it mid-instruction lets the current instruction complete.
- HALT is exited only by reset.
- Aliasing: A, B or the instruction word may alias each other. Reads always return current memory contents, and the write lands after both reads.
- Reset (async, iRST_N = 0):
  - State = IDLE, IP = RESET_IP.
  - oMEM_REQ, oMEM_WE, oMEM_ADDR, oMEM_WDATA, oBUSY and oHALT = 0.
  - Latched A, B, J, va and vb = 0.
  - Reset mid-transaction drops oMEM_REQ immediately. The memory side must tolerate an abandoned request. A write abandoned before its ACK edge is not guaranteed to land.

Optional Feature:
- Macro SUBLEQ_TRACE_EN.
- Defined: adds ports oTRC_VALID (1), oTRC_IP (ADDR_W), oTRC_RES (DATA_W) and oTRC_TAKEN (1).
  - oTRC_VALID pulses for exactly one cycle, the cycle after each WRITE completion, including the halting instruction.
  - oTRC_IP carries the IP of the retired instruction, oTRC_RES carries res, oTRC_TAKEN carries leq.
  - All trace outputs are 0 on reset.
- Undefined: no trace ports, no trace logic; the core is otherwise identical.

Decomposition:
- Package subleq_pkg holds:
  - the state enum (IDLE, FETCH, LOAD_A, LOAD_B, WRITE, HALT);
  - field-extraction functions for A, B and J, parametrised by ADDR_W;
  - the DATA_W >= 3*ADDR_W check as an elaboration-time assertion.
- One sub-module, subleq_alu (combinational): inputs va and vb; outputs res and leq. The FSM, IP and memory port stay in subleq_core.

Test Plan:
- Zero-wait memory (ACK = 1), REL_ADDR = 0, ADDR_W = 13, DATA_W = 64.
  - Setup: mem[0] = {A=10, B=11, J=5}, mem[10] = 3, mem[11] = 7.
  - Expect: mem[11] = 4, IP = 1, 4 cycles per instruction.
- Same program with mem[10] = 7.
  - Expect: res = 0, branch taken, IP = 5.
- Signed branch test: mem[10] = 1, mem[11] = 0.
  - Expect: res = all-ones (-1), branch taken.
  - Checks the signed compare; an unsigned compare would not branch.
- REL_ADDR = 1, IP = 8190, ADDR_W = 13, offsets A=3, B=4.
  - Expect: reads at addresses 1 and 2 (wrap).
  - Not-taken branch: IP = 8191, then 0.
- Randomized ACK delays of 0-5 cycles.
  - Expect: REQ, WE, ADDR and WDATA stable until ACK.
  - Final memory matches a reference model after 200 instructions.
- Self-loop {J=0} with REL_ADDR = 1 and leq.
  - Expect: oHALT = 1, oBUSY = 0, IP frozen.
  - iRUN toggling has no effect; iRST_N low restores IP = RESET_IP and clears oHALT.
  - Reset asserted mid-LOAD_B drops REQ within the same cycle.
